// File: rtl/divider64_seq.sv
// Iterative radix-2 restoring divider for the BDPU arithmetic unit.
// One quotient bit is resolved per clock; results come back with a
// one-cycle done strobe and are held until the next accepted start.
// Optional build macro: DIV_SIGNED_EN adds a signed_op input that selects
// two's complement division (truncating toward zero).
module divider64_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef DIV_SIGNED_EN
    input  logic             signed_op,
`endif
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        ZERO,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] dvs_reg;
    logic [WIDTH-1:0] dvd_reg;

    logic             accept;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] quot_final;
    logic [WIDTH-1:0] rem_final;

`ifdef DIV_SIGNED_EN
    logic neg_q_in;
    logic neg_r_in;
    logic neg_q;
    logic neg_r;
`endif

    assign accept = start && ((state == IDLE) || (state == DONE));

    // Operand magnitudes presented to the unsigned core at accept time
    always_comb begin
        dvd_mag = dividend;
        dvs_mag = divisor;
`ifdef DIV_SIGNED_EN
        neg_r_in = signed_op && dividend[WIDTH-1];
        neg_q_in = signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        if (signed_op && dividend[WIDTH-1]) begin
            dvd_mag = -dividend;
        end
        if (signed_op && divisor[WIDTH-1]) begin
            dvs_mag = -divisor;
        end
`endif
    end

    // One restoring step: trial subtract, keep it if non-negative
    always_comb begin
        trial = {r_reg, q_reg[WIDTH-1]} - {1'b0, dvs_reg};
        q_next = {q_reg[WIDTH-2:0], ~trial[WIDTH]};
        if (trial[WIDTH]) begin
            r_next = {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};
        end else begin
            r_next = trial[WIDTH-1:0];
        end
    end

    // Sign fix-up of the final step's results (identity for unsigned)
    always_comb begin
        quot_final = q_next;
        rem_final  = r_next;
`ifdef DIV_SIGNED_EN
        if (neg_q) begin
            quot_final = -q_next;
        end
        if (neg_r) begin
            rem_final = -r_next;
        end
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and status outputs
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (divisor == '0) ? ZERO : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (cnt == LAST_CNT) begin
                    next_state = DONE;
                end
            end
            ZERO: begin
                next_state = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    next_state = (divisor == '0) ? ZERO : CALC;
                end else begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, iteration, and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            r_reg       <= '0;
            q_reg       <= '0;
            dvs_reg     <= '0;
            dvd_reg     <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else if (accept) begin
            cnt         <= '0;
            r_reg       <= '0;
            q_reg       <= dvd_mag;
            dvs_reg     <= dvs_mag;
            dvd_reg     <= dividend;
            div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q       <= neg_q_in;
            neg_r       <= neg_r_in;
`endif
        end else if (state == CALC) begin
            r_reg <= r_next;
            q_reg <= q_next;
            cnt   <= cnt + 1'b1;
            if (cnt == LAST_CNT) begin
                quotient  <= quot_final;
                remainder <= rem_final;
            end
        end else if (state == ZERO) begin
            quotient    <= '1;
            remainder   <= dvd_reg;
            div_by_zero <= 1'b1;
        end
    end

endmodule

// File: tb/tb_divider64_seq.sv
// Directed testbench for divider64_seq with a queue-based scoreboard.
// Expected results are computed from the operands when a start is driven
// and compared when the divider raises done.
module tb_divider64_seq;

    localparam int W = 64;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         signedOp;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   startCyc = 0;
    int   busyCnt  = 0;
    exp_t sb[$];

    logic [W-1:0] opA;
    logic [W-1:0] opB;
    int           doneSeen;

    divider64_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
`ifdef DIV_SIGNED_EN
        .signed_op   (signedOp),
`endif
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Hard stop in case the sequence itself stalls
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Advance one cycle and sample just after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (busy === 1'b1) busyCnt++;
    endtask

    task automatic checkVal(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive a one-cycle start and record the expected result
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t e;
        logic [W-1:0] minVal;
        minVal = {1'b1, {(W-1){1'b0}}};
        if (b == '0) begin
            e.q = '1;
            e.r = a;
            e.z = 1'b1;
        end else if (s) begin
            if (a == minVal && b == '1) begin
                e.q = minVal;
                e.r = '0;
            end else begin
                e.q = $signed(a) / $signed(b);
                e.r = $signed(a) % $signed(b);
            end
            e.z = 1'b0;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.z = 1'b0;
        end
        sb.push_back(e);
        dividend = a;
        divisor  = b;
        signedOp = s;
        start    = 1'b1;
        startCyc = cyc;
        busyCnt  = 0;
        step();
        start    = 1'b0;
        signedOp = 1'b0;
        dividend = {$urandom, $urandom};
        divisor  = {$urandom, $urandom};
    endtask

    // Wait (bounded) for done, then check latency, busy span and results
    task automatic checkOutput(input string tag, input int expLat);
        exp_t e;
        int   lat;
        checkVal({tag, "_done_early"}, {63'd0, done}, 64'd0);
        while (done !== 1'b1 && (cyc - startCyc) < 200) step();
        lat = cyc - startCyc;
        checkVal({tag, "_latency"}, lat, expLat);
        checkVal({tag, "_busy_cycles"}, busyCnt, (expLat == 2) ? 0 : W);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL %s_scoreboard observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            checkVal({tag, "_quotient"}, quotient, e.q);
            checkVal({tag, "_remainder"}, remainder, e.r);
            checkVal({tag, "_div_by_zero"}, {63'd0, div_by_zero}, {63'd0, e.z});
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        signedOp = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) step();
        checkVal("reset_busy", {63'd0, busy}, 64'd0);
        checkVal("reset_done", {63'd0, done}, 64'd0);
        checkVal("reset_quotient", quotient, 64'd0);
        checkVal("reset_remainder", remainder, 64'd0);
        checkVal("reset_dbz", {63'd0, div_by_zero}, 64'd0);
        rst = 1'b0;
        step();

        // Basic op, then a back-to-back op accepted in the done cycle
        applyStimulus(64'd100, 64'd7, 1'b0);
        checkOutput("t1_100_div_7", 65);
        checkVal("t1_const_q", quotient, 64'd14);
        checkVal("t1_const_r", remainder, 64'd2);
        applyStimulus(64'd5, 64'd9, 1'b0);
        checkOutput("b2b_5_div_9", 65);
        step();
        checkVal("b2b_done_single", {63'd0, done}, 64'd0);

        // Extreme operands
        applyStimulus('1, 64'd1, 1'b0);
        checkOutput("max_div_1", 65);
        step();
        applyStimulus('1, '1, 1'b0);
        checkOutput("max_div_max", 65);
        step();

        // Divide by zero, then a normal op must clear the flag
        applyStimulus(64'd42, 64'd0, 1'b0);
        checkOutput("dbz_42", 2);
        step();
        checkVal("dbz_done_single", {63'd0, done}, 64'd0);
        applyStimulus(64'd9, 64'd3, 1'b0);
        checkOutput("after_dbz", 65);
        step();

        // Start during CALC must be ignored
        applyStimulus(64'd1000, 64'd10, 1'b0);
        repeat (9) step();
        dividend = 64'd77;
        divisor  = 64'd0;
        start    = 1'b1;
        step();
        start    = 1'b0;
        checkOutput("ignored_start", 65);
        checkVal("ignored_const_q", quotient, 64'd100);
        step();

        // Reset in the middle of an operation aborts it silently
        applyStimulus(64'd123456, 64'd789, 1'b0);
        repeat (29) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkVal("abort_busy", {63'd0, busy}, 64'd0);
        checkVal("abort_done", {63'd0, done}, 64'd0);
        checkVal("abort_quotient", quotient, 64'd0);
        checkVal("abort_remainder", remainder, 64'd0);
        checkVal("abort_dbz", {63'd0, div_by_zero}, 64'd0);
        void'(sb.pop_front());
        doneSeen = 0;
        repeat (80) begin
            step();
            if (done === 1'b1) doneSeen++;
        end
        checkVal("abort_no_done", doneSeen, 0);
        applyStimulus(64'd123456, 64'd789, 1'b0);
        checkOutput("after_abort", 65);
        step();

        // A few random unsigned operations
        for (int i = 0; i < 3; i++) begin
            opA = {$urandom, $urandom};
            opB = {32'd0, $urandom} | 64'd1;
            applyStimulus(opA, opB, 1'b0);
            checkOutput("random", 65);
            step();
        end

`ifdef DIV_SIGNED_EN
        // Signed division cases
        applyStimulus(-64'sd100, 64'd7, 1'b1);
        checkOutput("s_neg100_div_7", 65);
        checkVal("s1_const_q", quotient, -64'sd14);
        checkVal("s1_const_r", remainder, -64'sd2);
        step();
        applyStimulus(64'd100, -64'sd7, 1'b1);
        checkOutput("s_100_div_neg7", 65);
        checkVal("s2_const_r", remainder, 64'd2);
        step();
        applyStimulus({1'b1, {(W-1){1'b0}}}, '1, 1'b1);
        checkOutput("s_min_div_neg1", 65);
        step();
        applyStimulus(-64'sd5, 64'd0, 1'b1);
        checkOutput("s_dbz", 2);
        step();
        applyStimulus(-64'sd100, 64'd7, 1'b0);
        checkOutput("s_unsigned_mode", 65);
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
